// File: rtl/itrx_spim_apb_fsm.sv
// SPI master frame engine for the SPI-to-APB slave bridge.
// Ports: req_* request handshake, rsp_* response, cs_n/sclk_en/mosi/miso serial.
module itrx_spim_apb_fsm #(
  parameter int ADDR_BITS_N = 3,
  parameter int DATA_BITS_M = 8,
  parameter int CPHA_MODE   = 1,
  parameter int TURN_CLKS   = 8,
  parameter int GAP_CLKS    = 2
) (
  input  logic                   sclk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_write,
  input  logic [ADDR_BITS_N-1:0] req_addr,
  input  logic [DATA_BITS_M-1:0] req_wdata,
  output logic                   rsp_valid,
  output logic [DATA_BITS_M-1:0] rsp_rdata,
  output logic                   cs_n,
  output logic                   sclk_en,
  output logic                   mosi,
  input  logic                   miso
);

  localparam int N  = ADDR_BITS_N;
  localparam int M  = DATA_BITS_M;
  localparam int MX1 = (N > M) ? N : M;
  localparam int MX2 = (MX1 > TURN_CLKS) ? MX1 : TURN_CLKS;
  localparam int MX  = (MX2 > GAP_CLKS) ? MX2 : GAP_CLKS;
  localparam int CW  = $clog2(MX + 1);

  localparam logic [CW-1:0] ADDR_LD = CW'(N - 1);
  localparam logic [CW-1:0] DATA_LD = CW'(M - 1);
  localparam logic [CW-1:0] TURN_LD = CW'(TURN_CLKS - 1);
  // The IDLE cycle closes the gap, so GAP itself lasts GAP_CLKS-1.
  localparam logic [CW-1:0] GAP_LD  =
    CW'((GAP_CLKS > 1) ? GAP_CLKS - 2 : 0);

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_LEAD  = 4'd1,
    S_RW    = 4'd2,
    S_ADDR  = 4'd3,
    S_WDATA = 4'd4,
    S_TURN  = 4'd5,
    S_RDATA = 4'd6,
    S_DONE  = 4'd7,
    S_GAP   = 4'd8
  } state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           tx_write_q, tx_write_d;
  logic [N-1:0]   addr_sr_q, addr_sr_d;
  logic [M-1:0]   wdata_sr_q, wdata_sr_d;
  logic           req_ready_q, req_ready_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic [M-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic           cs_n_q, cs_n_d;
  logic           sclk_en_q, sclk_en_d;
  logic           mosi_q, mosi_d;
  logic           rx_en_q, rx_en_d;
  logic [M-1:0]   rx_sr_q;
  logic           last;

  assign last = (cnt_q == '0);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    tx_write_d  = tx_write_q;
    addr_sr_d   = addr_sr_q;
    wdata_sr_d  = wdata_sr_q;
    rsp_rdata_d = rsp_rdata_q;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (req_valid && req_ready_q) begin
          tx_write_d = req_write;
          addr_sr_d  = req_addr;
          wdata_sr_d = req_wdata;
          state_d    = (CPHA_MODE != 0) ? S_LEAD : S_RW;
        end
      end
      S_LEAD: begin
        state_d = S_RW;
      end
      S_RW: begin
        state_d = S_ADDR;
        cnt_d   = ADDR_LD;
      end
      S_ADDR: begin
        if (last) begin
          state_d = tx_write_q ? S_WDATA : S_TURN;
          cnt_d   = tx_write_q ? DATA_LD : TURN_LD;
        end else begin
          cnt_d     = cnt_q - CW'(1);
          addr_sr_d = addr_sr_q << 1;
        end
      end
      S_WDATA: begin
        if (last) begin
          state_d = S_TURN;
          cnt_d   = TURN_LD;
        end else begin
          cnt_d      = cnt_q - CW'(1);
          wdata_sr_d = wdata_sr_q << 1;
        end
      end
      S_TURN: begin
        if (last) begin
          state_d = tx_write_q ? S_DONE : S_RDATA;
          cnt_d   = tx_write_q ? '0 : DATA_LD;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_RDATA: begin
        if (last) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_DONE: begin
        state_d = (GAP_CLKS > 1) ? S_GAP : S_IDLE;
        cnt_d   = GAP_LD;
      end
      S_GAP: begin
        if (last) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Outputs are registered against the state being entered.
    cs_n_d      = (state_d == S_IDLE) ||
                  (state_d == S_DONE) ||
                  (state_d == S_GAP);
    sclk_en_d   = ~cs_n_d;
    req_ready_d = (state_d == S_IDLE);
    rsp_valid_d = (state_d == S_DONE);
    rx_en_d     = (state_d == S_RDATA);

    mosi_d = 1'b0;
    case (state_d)
      S_RW:    mosi_d = tx_write_d;
      S_ADDR:  mosi_d = addr_sr_d[N-1];
      S_WDATA: mosi_d = wdata_sr_d[M-1];
      default: mosi_d = 1'b0;
    endcase

    if (state_d == S_DONE) begin
      rsp_rdata_d = tx_write_q ? '0 : rx_sr_q;
    end
  end

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      tx_write_q  <= 1'b0;
      addr_sr_q   <= '0;
      wdata_sr_q  <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      cs_n_q      <= 1'b1;
      sclk_en_q   <= 1'b0;
      mosi_q      <= 1'b0;
      rx_en_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tx_write_q  <= tx_write_d;
      addr_sr_q   <= addr_sr_d;
      wdata_sr_q  <= wdata_sr_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      cs_n_q      <= cs_n_d;
      sclk_en_q   <= sclk_en_d;
      mosi_q      <= mosi_d;
      rx_en_q     <= rx_en_d;
    end
  end

  // Slave launches on posedge, so sample mid-cycle.
  always_ff @(negedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      rx_sr_q <= '0;
    end else if (rx_en_q) begin
      rx_sr_q <= {rx_sr_q[M-2:0], miso};
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign cs_n      = cs_n_q;
  assign sclk_en   = sclk_en_q;
  assign mosi      = mosi_q;

endmodule

// File: tb/tb_itrx_spim_apb_fsm.sv
// Bench for itrx_spim_apb_fsm: default config plus CPHA0/N4/M16 config.
// Frame model builds the expected mosi bit list from the request fields.
module tb_itrx_spim_apb_fsm;

  logic        sclk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [3:0]  req_addr = '0;
  logic [15:0] req_wdata = '0;
  logic        miso = 1'b0;
  bit          sel = 1'b0;

  always #5 sclk = ~sclk;

  logic        v0, v1;
  logic        rdy0, rv0, cs0, en0, mo0;
  logic [7:0]  rd0;
  logic        rdy1, rv1, cs1, en1, mo1;
  logic [15:0] rd1;

  assign v0 = req_valid & ~sel;
  assign v1 = req_valid & sel;

  itrx_spim_apb_fsm u0 (
    .sclk(sclk), .rst_n(rst_n),
    .req_valid(v0), .req_ready(rdy0),
    .req_write(req_write),
    .req_addr(req_addr[2:0]),
    .req_wdata(req_wdata[7:0]),
    .rsp_valid(rv0), .rsp_rdata(rd0),
    .cs_n(cs0), .sclk_en(en0),
    .mosi(mo0), .miso(miso)
  );

  itrx_spim_apb_fsm #(
    .ADDR_BITS_N(4), .DATA_BITS_M(16),
    .CPHA_MODE(0)
  ) u1 (
    .sclk(sclk), .rst_n(rst_n),
    .req_valid(v1), .req_ready(rdy1),
    .req_write(req_write),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rv1), .rsp_rdata(rd1),
    .cs_n(cs1), .sclk_en(en1),
    .mosi(mo1), .miso(miso)
  );

  logic        req_ready, rsp_valid;
  logic        cs_n, sclk_en, mosi;
  logic [15:0] rsp_rdata;

  assign req_ready = sel ? rdy1 : rdy0;
  assign rsp_valid = sel ? rv1 : rv0;
  assign cs_n      = sel ? cs1 : cs0;
  assign sclk_en   = sel ? en1 : en0;
  assign mosi      = sel ? mo1 : mo0;
  assign rsp_rdata = sel ? rd1 : {8'h00, rd0};

  localparam int TURN = 8;
  localparam int GAP  = 2;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  // Called at a negedge. Returns at the negedge of the DONE cycle.
  task automatic run_frame(
    input  bit          w,
    input  logic [3:0]  a,
    input  logic [15:0] d,
    input  logic [15:0] sd,
    input  bit          keep,
    input  bit          nw,
    input  logic [3:0]  na,
    input  logic [15:0] nd,
    output int          hi,
    output logic [15:0] exp_rd
  );
    int cp, nb, mb, rs, n, len, bad, rdy_bad, en_bad;
    bit q[$];
    cp = sel ? 0 : 1;
    nb = sel ? 4 : 3;
    mb = sel ? 16 : 8;
    rs = cp + 1 + nb + TURN;
    if (cp != 0) q.push_back(1'b0);
    q.push_back(w);
    for (int i = nb - 1; i >= 0; i--) q.push_back(a[i]);
    if (w) for (int i = mb - 1; i >= 0; i--) q.push_back(d[i]);
    for (int i = 0; i < TURN; i++) q.push_back(1'b0);
    if (!w) for (int i = 0; i < mb; i++) q.push_back(1'b0);
    exp_rd = w ? 16'h0 : (sel ? sd : {8'h00, sd[7:0]});

    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    n = 0;
    while (cs_n === 1'b1 && n < 40) begin
      @(posedge sclk); #1 miso = 1'($urandom);
      @(negedge sclk);
      n++;
    end
    hi = n;
    check("accept_cs_low", cs_n, 1'b0);
    if (cs_n !== 1'b0) begin
      req_valid = 1'b0;
      return;
    end
    if (keep) begin
      req_write = nw;
      req_addr  = na;
      req_wdata = nd;
    end else begin
      req_valid = 1'b0;
      req_write = 1'($urandom);
      req_addr  = 4'($urandom);
      req_wdata = 16'($urandom);
    end
    len = 0; bad = 0; rdy_bad = 0; en_bad = 0;
    while (cs_n === 1'b0 && len < 100) begin
      if (len < q.size() && mosi !== q[len]) bad++;
      if (req_ready !== 1'b0 || rsp_valid !== 1'b0) rdy_bad++;
      if (sclk_en !== 1'b1) en_bad++;
      len++;
      @(posedge sclk); #1;
      if (len >= rs && len < rs + mb)
        miso = sd[mb - 1 - (len - rs)];
      else
        miso = 1'($urandom);
      @(negedge sclk);
    end
    check("frame_len", len, q.size());
    check("mosi_bits_wrong", bad, 0);
    check("busy_ready_or_rsp", rdy_bad, 0);
    check("busy_sclk_en", en_bad, 0);
    check("done_rsp_valid", rsp_valid, 1'b1);
    check("done_rsp_rdata", rsp_rdata, exp_rd);
    check("done_sclk_en", sclk_en, 1'b0);
  endtask

  task automatic finish_idle(input logic [15:0] exp_rd);
    int n;
    @(negedge sclk);
    check("rsp_single_pulse", rsp_valid, 1'b0);
    n = 0;
    while (req_ready !== 1'b1 && n < 20) begin
      @(negedge sclk);
      n++;
    end
    check("idle_ready", req_ready, 1'b1);
    check("idle_cs_n", cs_n, 1'b1);
    check("rdata_hold", rsp_rdata, exp_rd);
  endtask

  initial begin
    int hi, n, bad;
    logic [15:0] erd;
    bit w;
    logic [3:0] a;
    logic [15:0] d, sd;

    repeat (2) @(negedge sclk);
    check("rst_req_ready", req_ready, 1'b1);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_rdata", rsp_rdata, 16'h0);
    check("rst_cs_n", cs_n, 1'b1);
    check("rst_sclk_en", sclk_en, 1'b0);
    check("rst_mosi", mosi, 1'b0);
    rst_n = 1'b1;
    @(negedge sclk);

    // Directed write and read, default config.
    run_frame(1, 4'h5, 16'h00A5, 16'h0, 0, 0, 0, 0, hi, erd);
    finish_idle(erd);
    run_frame(0, 4'h2, 16'h0, 16'h003C, 0, 0, 0, 0, hi, erd);
    check("read_3c", erd, 16'h003C);
    finish_idle(erd);

    // Back-to-back with valid held; fields change while busy.
    run_frame(1, 4'h3, 16'h005A, 16'h0, 1, 1, 4'h6, 16'h00C3, hi, erd);
    run_frame(1, 4'h6, 16'h00C3, 16'h0, 0, 0, 0, 0, hi, erd);
    check("b2b_gap_high", hi, GAP + 1);
    finish_idle(erd);

    // Async reset during the address phase.
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 4'h7;
    n = 0;
    while (cs_n === 1'b1 && n < 20) begin
      @(negedge sclk);
      n++;
    end
    check("rst_test_start", cs_n, 1'b0);
    req_valid = 1'b0;
    repeat (2) @(negedge sclk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_cs_n", cs_n, 1'b1);
    check("arst_sclk_en", sclk_en, 1'b0);
    check("arst_ready", req_ready, 1'b1);
    @(negedge sclk);
    #2 rst_n = 1'b1;
    @(negedge sclk);
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      if (rsp_valid !== 1'b0 || cs_n !== 1'b1) bad++;
      @(negedge sclk);
    end
    check("arst_no_rsp", bad, 0);
    run_frame(0, 4'h1, 16'h0, 16'h0096, 0, 0, 0, 0, hi, erd);
    finish_idle(erd);

    // Randomized frames, default config.
    for (int i = 0; i < 10; i++) begin
      w  = 1'($urandom);
      a  = 4'($urandom_range(0, 7));
      d  = 16'($urandom_range(0, 255));
      sd = 16'($urandom_range(0, 255));
      run_frame(w, a, d, sd, 0, 0, 0, 0, hi, erd);
      finish_idle(erd);
    end

    // Second configuration: no lead clock, N=4, M=16.
    sel = 1'b1;
    @(negedge sclk);
    check("cfg1_first_bit_rw", mosi, 1'b0);
    run_frame(1, 4'hF, 16'h8001, 16'h0, 0, 0, 0, 0, hi, erd);
    finish_idle(erd);
    for (int i = 0; i < 4; i++) begin
      w  = 1'($urandom);
      a  = 4'($urandom);
      d  = 16'($urandom);
      sd = 16'($urandom);
      run_frame(w, a, d, sd, 0, 0, 0, 0, hi, erd);
      finish_idle(erd);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
